riscv_wb_arbiter: RTL and testbench

- Shares the single register-file write port among NUM_REQ writeback sources: ALU, LSU, MUL/DIV and CSR.
- Each source presents a valid/ready request carrying a destination index and value.
- Grants one request per cycle using round-robin priority.
- Drives a registered write (rd_we_o/rd_idx_o/rd_val_o) straight into the regfile write port one cycle after the grant.

---
 rtl/riscv_wb_arbiter_if.sv | 27 ++
 rtl/riscv_wb_arbiter.sv | 116 +++++++++++
 tb/tb_riscv_wb_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/riscv_wb_arbiter_if.sv
// Writeback request/regfile-write bundle shared between the writeback sources and riscv_wb_arbiter.
// master = requester/environment side, slave = arbiter side.
interface riscv_wb_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int XLEN    = 32,
    parameter int AW      = 5
);
    logic [NUM_REQ-1:0]      req_valid_i;
    logic [NUM_REQ-1:0]      req_ready_o;
    logic [NUM_REQ*AW-1:0]   req_rd_idx_i;
    logic [NUM_REQ*XLEN-1:0] req_rd_val_i;
    logic                    wb_stall_i;
    logic                    rd_we_o;
    logic [AW-1:0]           rd_idx_o;
    logic [XLEN-1:0]         rd_val_o;
    logic [2:0]              grant_idx_o;

    modport master (
        output req_valid_i, req_rd_idx_i, req_rd_val_i, wb_stall_i,
        input  req_ready_o, rd_we_o, rd_idx_o, rd_val_o, grant_idx_o
    );

    modport slave (
        input  req_valid_i, req_rd_idx_i, req_rd_val_i, wb_stall_i,
        output req_ready_o, rd_we_o, rd_idx_o, rd_val_o, grant_idx_o
    );
endinterface

// File: rtl/riscv_wb_arbiter.sv
// Round-robin arbiter sharing the single regfile write port among NUM_REQ writeback sources.
// Define WB_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no rotating pointer).
module riscv_wb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int XLEN    = 32,
    parameter int AW      = 5
) (
    input  logic               clk,
    input  logic               rst,
    riscv_wb_arbiter_if.slave  wb
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic               arb_en;
    logic               grant_vld;
    logic [PW-1:0]      grant_k;
    logic [NUM_REQ-1:0] ready;

    logic               rd_we_q,     rd_we_d;
    logic [AW-1:0]      rd_idx_q,    rd_idx_d;
    logic [XLEN-1:0]    rd_val_q,    rd_val_d;
    logic [2:0]         grant_idx_q, grant_idx_d;

    // Ready is gated by rst so no requester sees an accept while the block is held in reset.
    assign arb_en = !rst && !wb.wb_stall_i;

`ifdef WB_ARB_FIXED_PRIO_EN
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        grant_vld = 1'b0;
        grant_k   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (wb.req_valid_i[i]) begin
                grant_vld = 1'b1;
                grant_k   = PW'(i);
            end
        end
        if (!arb_en) grant_vld = 1'b0;
    end
`else
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] cand;

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        return PW'(s % NUM_REQ);
    endfunction

    // Walk the offsets downwards so the requester closest to ptr is the one left standing.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        grant_vld = 1'b0;
        grant_k   = '0;
        cand      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = wrap_add(ptr_q, i);
            if (wb.req_valid_i[cand]) begin
                grant_vld = 1'b1;
                grant_k   = cand;
            end
        end
        if (!arb_en) grant_vld = 1'b0;

        ptr_d = ptr_q;
        if (grant_vld) begin
            ptr_d = (grant_k == PW'(NUM_REQ - 1)) ? '0 : grant_k + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
`endif

    always_comb begin
        ready = '0;
        if (grant_vld) ready[grant_k] = 1'b1;
    end

    // x0 writes are accepted but never reach the regfile; idx/val/grant still capture them for trace.
    always_comb begin
        rd_we_d     = 1'b0;
        rd_idx_d    = rd_idx_q;
        rd_val_d    = rd_val_q;
        grant_idx_d = grant_idx_q;
        if (grant_vld) begin
            rd_idx_d    = wb.req_rd_idx_i[grant_k*AW +: AW];
            rd_val_d    = wb.req_rd_val_i[grant_k*XLEN +: XLEN];
            grant_idx_d = 3'(grant_k);
            rd_we_d     = (rd_idx_d != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_we_q     <= 1'b0;
            rd_idx_q    <= '0;
            rd_val_q    <= '0;
            grant_idx_q <= '0;
        end else begin
            rd_we_q     <= rd_we_d;
            rd_idx_q    <= rd_idx_d;
            rd_val_q    <= rd_val_d;
            grant_idx_q <= grant_idx_d;
        end
    end

    assign wb.req_ready_o = ready;
    assign wb.rd_we_o     = rd_we_q;
    assign wb.rd_idx_o    = rd_idx_q;
    assign wb.rd_val_o    = rd_val_q;
    assign wb.grant_idx_o = grant_idx_q;
endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Directed bench for riscv_wb_arbiter (default round-robin build); every expected value is a hand-computed constant.
module tb_riscv_wb_arbiter;
    localparam int NUM_REQ = 4;
    localparam int XLEN    = 32;
    localparam int AW      = 5;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    riscv_wb_arbiter_if #(.NUM_REQ(NUM_REQ), .XLEN(XLEN), .AW(AW)) wb ();

    riscv_wb_arbiter #(.NUM_REQ(NUM_REQ), .XLEN(XLEN), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb)
    );

    task automatic set_req(input int k, input logic [AW-1:0] idx, input logic [XLEN-1:0] val);
        wb.req_rd_idx_i[k*AW +: AW]     = idx;
        wb.req_rd_val_i[k*XLEN +: XLEN] = val;
    endtask

    // Pulse rst away from the clock edge; returns 1 time unit after a rising edge.
    task automatic do_reset();
        wb.req_valid_i = '0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        wb.req_valid_i = 4'b1111;
        @(posedge clk); @(posedge clk); #1;
        checks++; if (wb.req_ready_o !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want %b", wb.req_ready_o, 4'b0000); end
        checks++; if (wb.rd_we_o !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", wb.rd_we_o); end
        checks++; if (wb.rd_idx_o !== 5'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", wb.rd_idx_o); end
        checks++; if (wb.rd_val_o !== 32'h0) begin errors++; $display("FAIL reset_val: got %h want 0", wb.rd_val_o); end
        checks++; if (wb.grant_idx_o !== 3'd0) begin errors++; $display("FAIL reset_grant: got %0d want 0", wb.grant_idx_o); end
        wb.req_valid_i = '0;
        #2 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        set_req(0, 5'd5, 32'hDEADBEEF);
        wb.req_valid_i = 4'b0001;
        #1;
        checks++; if (wb.req_ready_o !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b want %b", wb.req_ready_o, 4'b0001); end
        @(posedge clk); #1;
        wb.req_valid_i = '0;
        checks++; if (wb.rd_we_o !== 1'b1) begin errors++; $display("FAIL single_we: got %b want 1", wb.rd_we_o); end
        checks++; if (wb.rd_idx_o !== 5'd5) begin errors++; $display("FAIL single_idx: got %0d want 5", wb.rd_idx_o); end
        checks++; if (wb.rd_val_o !== 32'hDEADBEEF) begin errors++; $display("FAIL single_val: got %h want deadbeef", wb.rd_val_o); end
        checks++; if (wb.grant_idx_o !== 3'd0) begin errors++; $display("FAIL single_grant: got %0d want 0", wb.grant_idx_o); end
        @(posedge clk); #1;
        checks++; if (wb.rd_we_o !== 1'b0) begin errors++; $display("FAIL single_we_drop: got %b want 0", wb.rd_we_o); end
        checks++; if (wb.rd_idx_o !== 5'd5) begin errors++; $display("FAIL single_idx_hold: got %0d want 5", wb.rd_idx_o); end
    endtask

    task automatic test_round_robin();
        int order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        logic [3:0] want_rdy;
        do_reset();
        for (int k = 0; k < NUM_REQ; k++) set_req(k, AW'(k + 1), 32'hA000_0000 + k);
        wb.req_valid_i = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            want_rdy = 4'b0001 << order[i];
            #1;
            checks++; if (wb.req_ready_o !== want_rdy) begin errors++; $display("FAIL rr_ready[%0d]: got %b want %b", i, wb.req_ready_o, want_rdy); end
            @(posedge clk); #1;
            checks++; if (wb.rd_we_o !== 1'b1) begin errors++; $display("FAIL rr_we[%0d]: got %b want 1", i, wb.rd_we_o); end
            checks++; if (wb.grant_idx_o !== 3'(order[i])) begin errors++; $display("FAIL rr_grant[%0d]: got %0d want %0d", i, wb.grant_idx_o, order[i]); end
            checks++; if (wb.rd_idx_o !== AW'(order[i] + 1)) begin errors++; $display("FAIL rr_idx[%0d]: got %0d want %0d", i, wb.rd_idx_o, order[i] + 1); end
        end
        wb.req_valid_i = '0;
        @(posedge clk); #1;
        checks++; if (wb.rd_we_o !== 1'b0) begin errors++; $display("FAIL rr_idle_we: got %b want 0", wb.rd_we_o); end
    endtask

    // Entry ptr=0: grant 2 moves ptr to 3, then 4'b1010 must give 3, wrap to 0, then give 1.
    task automatic test_wrap();
        set_req(1, 5'd7,  32'h11);
        set_req(2, 5'd9,  32'h22);
        set_req(3, 5'd31, 32'h33);
        wb.req_valid_i = 4'b0100;
        #1;
        checks++; if (wb.req_ready_o !== 4'b0100) begin errors++; $display("FAIL wrap_ready_a: got %b want %b", wb.req_ready_o, 4'b0100); end
        @(posedge clk); #1;
        checks++; if (wb.grant_idx_o !== 3'd2) begin errors++; $display("FAIL wrap_grant_a: got %0d want 2", wb.grant_idx_o); end
        wb.req_valid_i = 4'b1010;
        #1;
        checks++; if (wb.req_ready_o !== 4'b1000) begin errors++; $display("FAIL wrap_ready_b: got %b want %b", wb.req_ready_o, 4'b1000); end
        @(posedge clk); #1;
        checks++; if (wb.grant_idx_o !== 3'd3) begin errors++; $display("FAIL wrap_grant_b: got %0d want 3", wb.grant_idx_o); end
        checks++; if (wb.rd_idx_o !== 5'd31) begin errors++; $display("FAIL wrap_idx_b: got %0d want 31", wb.rd_idx_o); end
        checks++; if (wb.rd_val_o !== 32'h33) begin errors++; $display("FAIL wrap_val_b: got %h want 33", wb.rd_val_o); end
        #1;
        checks++; if (wb.req_ready_o !== 4'b0010) begin errors++; $display("FAIL wrap_ready_c: got %b want %b", wb.req_ready_o, 4'b0010); end
        @(posedge clk); #1;
        wb.req_valid_i = '0;
        checks++; if (wb.grant_idx_o !== 3'd1) begin errors++; $display("FAIL wrap_grant_c: got %0d want 1", wb.grant_idx_o); end
        checks++; if (wb.rd_idx_o !== 5'd7) begin errors++; $display("FAIL wrap_idx_c: got %0d want 7", wb.rd_idx_o); end
        @(posedge clk); #1;
    endtask

    // Entry ptr=2: an x0 write is accepted silently and still moves ptr to 3.
    task automatic test_x0();
        set_req(2, 5'd0, 32'h1234);
        wb.req_valid_i = 4'b0100;
        #1;
        checks++; if (wb.req_ready_o !== 4'b0100) begin errors++; $display("FAIL x0_ready: got %b want %b", wb.req_ready_o, 4'b0100); end
        @(posedge clk); #1;
        checks++; if (wb.rd_we_o !== 1'b0) begin errors++; $display("FAIL x0_we: got %b want 0", wb.rd_we_o); end
        checks++; if (wb.grant_idx_o !== 3'd2) begin errors++; $display("FAIL x0_grant: got %0d want 2", wb.grant_idx_o); end
        checks++; if (wb.rd_val_o !== 32'h1234) begin errors++; $display("FAIL x0_val: got %h want 1234", wb.rd_val_o); end
        set_req(3, 5'd12, 32'h5678);
        wb.req_valid_i = 4'b1100;
        #1;
        checks++; if (wb.req_ready_o !== 4'b1000) begin errors++; $display("FAIL x0_ptr_ready: got %b want %b", wb.req_ready_o, 4'b1000); end
        @(posedge clk); #1;
        wb.req_valid_i = '0;
        checks++; if (wb.rd_we_o !== 1'b1) begin errors++; $display("FAIL x0_next_we: got %b want 1", wb.rd_we_o); end
        checks++; if (wb.grant_idx_o !== 3'd3) begin errors++; $display("FAIL x0_next_grant: got %0d want 3", wb.grant_idx_o); end
        @(posedge clk); #1;
    endtask

    // Entry ptr=0.
    task automatic test_stall();
        set_req(2, 5'd9, 32'h22);
        wb.wb_stall_i  = 1'b1;
        wb.req_valid_i = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (wb.req_ready_o !== 4'b0000) begin errors++; $display("FAIL stall_ready[%0d]: got %b want %b", i, wb.req_ready_o, 4'b0000); end
            @(posedge clk); #1;
            checks++; if (wb.rd_we_o !== 1'b0) begin errors++; $display("FAIL stall_we[%0d]: got %b want 0", i, wb.rd_we_o); end
        end
        wb.wb_stall_i = 1'b0;
        #1;
        checks++; if (wb.req_ready_o !== 4'b0100) begin errors++; $display("FAIL stall_release_ready: got %b want %b", wb.req_ready_o, 4'b0100); end
        @(posedge clk); #1;
        checks++; if (wb.rd_we_o !== 1'b1) begin errors++; $display("FAIL stall_release_we: got %b want 1", wb.rd_we_o); end
        checks++; if (wb.grant_idx_o !== 3'd2) begin errors++; $display("FAIL stall_release_grant: got %0d want 2", wb.grant_idx_o); end
        // ptr is now 3 and must survive a stalled cycle with requesters 0 and 3 pending.
        set_req(0, 5'd3, 32'h3);
        set_req(3, 5'd4, 32'h4);
        wb.wb_stall_i  = 1'b1;
        wb.req_valid_i = 4'b1001;
        @(posedge clk); #1;
        wb.wb_stall_i = 1'b0;
        #1;
        checks++; if (wb.req_ready_o !== 4'b1000) begin errors++; $display("FAIL stall_ptr_ready: got %b want %b", wb.req_ready_o, 4'b1000); end
        @(posedge clk); #1;
        wb.req_valid_i = '0;
        checks++; if (wb.rd_idx_o !== 5'd4) begin errors++; $display("FAIL stall_ptr_idx: got %0d want 4", wb.rd_idx_o); end
        @(posedge clk); #1;
    endtask

    // Entry ptr=0: grant 1 moves ptr to 2; reset must pull it back so 4'b0110 grants 1, not 2.
    task automatic test_async_reset();
        set_req(1, 5'd6, 32'h66);
        wb.req_valid_i = 4'b0010;
        #1;
        checks++; if (wb.req_ready_o !== 4'b0010) begin errors++; $display("FAIL arst_pre_ready: got %b want %b", wb.req_ready_o, 4'b0010); end
        @(posedge clk); #1;
        wb.req_valid_i = '0;
        checks++; if (wb.rd_we_o !== 1'b1) begin errors++; $display("FAIL arst_pre_we: got %b want 1", wb.rd_we_o); end
        #2;
        rst = 1'b1;
        set_req(2, 5'd8, 32'h88);
        wb.req_valid_i = 4'b0110;
        #1;
        checks++; if (wb.rd_we_o !== 1'b0) begin errors++; $display("FAIL arst_we: got %b want 0", wb.rd_we_o); end
        checks++; if (wb.rd_idx_o !== 5'd0) begin errors++; $display("FAIL arst_idx: got %0d want 0", wb.rd_idx_o); end
        checks++; if (wb.grant_idx_o !== 3'd0) begin errors++; $display("FAIL arst_grant: got %0d want 0", wb.grant_idx_o); end
        checks++; if (wb.req_ready_o !== 4'b0000) begin errors++; $display("FAIL arst_ready: got %b want %b", wb.req_ready_o, 4'b0000); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (wb.req_ready_o !== 4'b0010) begin errors++; $display("FAIL arst_post_ready: got %b want %b", wb.req_ready_o, 4'b0010); end
        @(posedge clk); #1;
        wb.req_valid_i = '0;
        checks++; if (wb.grant_idx_o !== 3'd1) begin errors++; $display("FAIL arst_post_grant: got %0d want 1", wb.grant_idx_o); end
        checks++; if (wb.rd_val_o !== 32'h66) begin errors++; $display("FAIL arst_post_val: got %h want 66", wb.rd_val_o); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst             = 1'b1;
        wb.req_valid_i  = '0;
        wb.req_rd_idx_i = '0;
        wb.req_rd_val_i = '0;
        wb.wb_stall_i   = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_x0();
        test_stall();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
